// File: rtl/operand_selector_param_if.sv
// operand_selector_param_if: control, metadata and result signals of the operand selector
interface operand_selector_param_if #(
  parameter int NUM_SLOTS = 10,
  parameter int ID_W = 4,
  parameter int DIM_W = 3
);
  logic start_select;
  logic abort;
  logic manual_mode;
  logic [2:0] op_type;
  logic [ID_W-1:0] user_id_a;
  logic [ID_W-1:0] user_id_b;
  logic user_input_valid;
  logic [NUM_SLOTS*DIM_W-1:0] meta_m_flat;
  logic [NUM_SLOTS*DIM_W-1:0] meta_n_flat;
  logic [NUM_SLOTS-1:0] meta_valid;
  logic [ID_W-1:0] selected_a;
  logic [ID_W-1:0] selected_b;
  logic select_done;
  logic select_error;
  logic [2:0] err_code;
  logic busy;
  modport master (
    output start_select, abort, manual_mode, op_type, user_id_a, user_id_b, user_input_valid,
    output meta_m_flat, meta_n_flat, meta_valid,
    input selected_a, selected_b, select_done, select_error, err_code, busy
  );
  modport slave (
    input start_select, abort, manual_mode, op_type, user_id_a, user_id_b, user_input_valid,
    input meta_m_flat, meta_n_flat, meta_valid,
    output selected_a, selected_b, select_done, select_error, err_code, busy
  );
endinterface

// File: rtl/operand_selector_param.sv
// operand_selector_param: picks matrix operand IDs manually or by LFSR draws with linear-scan fallback
module operand_selector_param #(
  parameter int NUM_SLOTS = 10,
  parameter int ID_W = 4,
  parameter int DIM_W = 3,
  parameter int MAX_TRIES = 10,
  parameter int TIMEOUT = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  operand_selector_param_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, WAIT_INPUT = 3'd1, RAND_A = 3'd2, SCAN_A = 3'd3;
  localparam logic [2:0] RAND_B = 3'd4, SCAN_B = 3'd5, VALIDATE = 3'd6, ERROR = 3'd7;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int OW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [OW-1:0] TMO_LAST = OW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0] IDX_LAST = ID_W'(NUM_SLOTS - 1);
  localparam logic [ID_W:0] NS = (ID_W + 1)'(NUM_SLOTS);
  typedef logic [NUM_SLOTS*DIM_W-1:0] flat_t;
  function automatic logic [DIM_W-1:0] dim(input flat_t f, input logic [ID_W-1:0] id);
    dim = '0;
    for (int i = 0; i < NUM_SLOTS; i++) if (id == i[ID_W-1:0]) dim = f[i*DIM_W +: DIM_W];
  endfunction
  function automatic logic vld(input logic [NUM_SLOTS-1:0] v, input logic [ID_W-1:0] id);
    vld = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) if (id == i[ID_W-1:0]) vld = v[i];
  endfunction
  function automatic logic in_range(input logic [ID_W-1:0] id);
    return {1'b0, id} < NS;
  endfunction
  function automatic logic compat(input logic [2:0] op, input logic [DIM_W-1:0] ma, na, mb, nb);
    return (op == 3'd0 || op == 3'd2) ? 1'b1 :
           (op == 3'd1) ? (ma == mb && na == nb) :
           (op == 3'd3) ? (na == mb) :
           (op == 3'd4) ? (mb <= ma && nb <= na) : 1'b0;
  endfunction
  logic [2:0] state_q, state_d, code_q, code_d, v_code, op;
  logic [15:0] lfsr_q;
  logic [TW-1:0] try_q, try_d;
  logic [OW-1:0] tmo_q, tmo_d;
  logic [ID_W-1:0] idx_q, idx_d, a_q, a_d, b_q, b_d, cand;
  logic [DIM_W-1:0] ma, na;
  logic done_q, done_d, err_q, err_d, single, a_hit, b_hit;
  assign op = bus.op_type;
  assign single = op == 3'd0 || op == 3'd2;
  assign cand = (state_q == RAND_A || state_q == RAND_B) ? lfsr_q[ID_W-1:0] : idx_q;
  assign ma = dim(bus.meta_m_flat, a_q);
  assign na = dim(bus.meta_n_flat, a_q);
  assign a_hit = vld(bus.meta_valid, cand);
  assign b_hit = a_hit && compat(op, ma, na, dim(bus.meta_m_flat, cand), dim(bus.meta_n_flat, cand));
  // first failing rule wins: range, opcode, A valid, B valid, dimensions
  assign v_code = (!in_range(a_q) || (!single && !in_range(b_q))) ? 3'd4 :
                  (op > 3'd4) ? 3'd7 :
                  !vld(bus.meta_valid, a_q) ? 3'd1 :
                  (!single && !vld(bus.meta_valid, b_q)) ? 3'd2 :
                  !compat(op, ma, na, dim(bus.meta_m_flat, b_q), dim(bus.meta_n_flat, b_q)) ? 3'd3 : 3'd0;
  always_comb begin
    state_d = state_q;
    try_d = try_q;
    tmo_d = tmo_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    done_d = 1'b0;
    err_d = err_q;
    code_d = code_q;
    if (bus.abort) begin
      state_d = IDLE;
      err_d = 1'b0;
      code_d = 3'd0;
    end else case (state_q)
      IDLE, ERROR: if (bus.start_select) begin
        err_d = 1'b0;
        code_d = 3'd0;
        try_d = '0;
        tmo_d = '0;
        idx_d = '0;
        state_d = bus.manual_mode ? WAIT_INPUT : RAND_A;
      end
      WAIT_INPUT: if (bus.user_input_valid) begin
        a_d = bus.user_id_a;
        b_d = bus.user_id_b;
        state_d = VALIDATE;
      end else if (TIMEOUT > 0 && tmo_q == TMO_LAST) begin
        state_d = ERROR;
        err_d = 1'b1;
        code_d = 3'd5;
      end else tmo_d = tmo_q + 1'b1;
      RAND_A, SCAN_A: if (a_hit) begin
        a_d = cand;
        b_d = cand;
        try_d = '0;
        idx_d = '0;
        state_d = (single || op > 3'd4) ? VALIDATE : RAND_B;
      end else if (state_q == RAND_A) begin
        try_d = try_q + 1'b1;
        if (try_q == TRY_LAST) state_d = SCAN_A;
      end else if (idx_q == IDX_LAST) begin
        state_d = ERROR;
        err_d = 1'b1;
        code_d = 3'd1;
      end else idx_d = idx_q + 1'b1;
      RAND_B, SCAN_B: if (b_hit) begin
        b_d = cand;
        state_d = VALIDATE;
      end else if (state_q == RAND_B) begin
        try_d = try_q + 1'b1;
        if (try_q == TRY_LAST) state_d = SCAN_B;
      end else if (idx_q == IDX_LAST) begin
        state_d = ERROR;
        err_d = 1'b1;
        code_d = 3'd6;
      end else idx_d = idx_q + 1'b1;
      default: begin
        done_d = v_code == 3'd0;
        err_d = v_code != 3'd0;
        code_d = v_code;
        state_d = (v_code == 3'd0) ? IDLE : ERROR;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      try_q <= '0;
      tmo_q <= '0;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= 3'd0;
    end else begin
      state_q <= state_d;
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      try_q <= try_d;
      tmo_q <= tmo_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
  assign bus.selected_a = a_q;
  assign bus.selected_b = b_q;
  assign bus.select_done = done_q;
  assign bus.select_error = err_q;
  assign bus.err_code = code_q;
  assign bus.busy = state_q != IDLE && state_q != ERROR;
endmodule

// File: tb/tb_operand_selector_param.sv
// tb_operand_selector_param: directed checks of manual, random, timeout, abort and reset behaviour
module tb_operand_selector_param;
  logic clk, rst_n;
  int vectors = 0, miscompares = 0;
  logic [15:0] lm;
  operand_selector_param_if #(.NUM_SLOTS(10), .ID_W(4), .DIM_W(3)) bus ();
  operand_selector_param #(.NUM_SLOTS(10), .ID_W(4), .DIM_W(3), .MAX_TRIES(10), .TIMEOUT(20),
                           .LFSR_SEED(16'hACE1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  always_ff @(posedge clk or negedge rst_n) lm <= !rst_n ? 16'hACE1 : nxt(lm);
  // predicted slot from up to 10 random draws then a scan; n = cycles consumed
  function automatic logic [3:0] pick(input logic [15:0] l0, input logic [15:0] mask,
                                      output logic [15:0] l_out, output int n);
    logic [15:0] l;
    logic [3:0] c;
    l = l0;
    n = 0;
    pick = 4'hF;
    for (int t = 0; t < 10; t++) begin
      c = l[3:0];
      l = nxt(l);
      n++;
      if (c < 4'd10 && mask[c]) begin
        l_out = l;
        return c;
      end
    end
    for (int i = 0; i < 10; i++) begin
      l = nxt(l);
      n++;
      if (mask[i]) begin
        l_out = l;
        return 4'(i);
      end
    end
    l_out = l;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic v, input logic [2:0] m, input logic [2:0] n);
    bus.meta_valid[i] = v;
    bus.meta_m_flat[i*3 +: 3] = m;
    bus.meta_n_flat[i*3 +: 3] = n;
  endtask
  task automatic clr_slots();
    bus.meta_valid = '0;
    bus.meta_m_flat = '0;
    bus.meta_n_flat = '0;
  endtask
  task automatic start(input logic man, input logic [2:0] op);
    bus.manual_mode = man;
    bus.op_type = op;
    bus.start_select = 1'b1;
    tick();
    bus.start_select = 1'b0;
  endtask
  task automatic manual(input logic [2:0] op, input logic [3:0] ua, input logic [3:0] ub);
    bus.user_id_a = ua;
    bus.user_id_b = ub;
    start(1'b1, op);
    bus.user_input_valid = 1'b1;
    tick();
    bus.user_input_valid = 1'b0;
    tick();
  endtask
  task automatic wait_result(input string tag);
    int n = 0;
    while (!bus.select_done && !bus.select_error && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ended"}, 32'(bus.select_done | bus.select_error), 1);
  endtask
  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] l0, la, lb;
    logic [3:0] pa, pb;
    int na, nb;
    rst_n = 1'b0;
    bus.start_select = 1'b0;
    bus.abort = 1'b0;
    bus.manual_mode = 1'b0;
    bus.op_type = 3'd0;
    bus.user_id_a = '0;
    bus.user_id_b = '0;
    bus.user_input_valid = 1'b0;
    clr_slots();
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.select_done), 0);
    chk("rst_err", 32'(bus.select_error), 0);
    chk("rst_code", 32'(bus.err_code), 0);
    chk("rst_a", 32'(bus.selected_a), 0);
    chk("rst_b", 32'(bus.selected_b), 0);
    rst_n = 1'b1;
    tick();
    set_slot(2, 1'b1, 3'd3, 3'd3);
    set_slot(5, 1'b1, 3'd3, 3'd3);
    bus.user_id_a = 4'd2;
    bus.user_id_b = 4'd5;
    start(1'b1, 3'd1);
    chk("add_busy_wait", 32'(bus.busy), 1);
    bus.user_input_valid = 1'b1;
    tick();
    bus.user_input_valid = 1'b0;
    chk("add_done_e0", 32'(bus.select_done), 0);
    tick();
    chk("add_done_e1", 32'(bus.select_done), 1);
    chk("add_a", 32'(bus.selected_a), 2);
    chk("add_b", 32'(bus.selected_b), 5);
    chk("add_code", 32'(bus.err_code), 0);
    chk("add_busy_idle", 32'(bus.busy), 0);
    tick();
    chk("add_done_e2", 32'(bus.select_done), 0);
    set_slot(1, 1'b1, 3'd2, 3'd3);
    set_slot(4, 1'b1, 3'd2, 3'd2);
    manual(3'd3, 4'd1, 4'd4);
    chk("mul_err", 32'(bus.select_error), 1);
    chk("mul_code", 32'(bus.err_code), 3);
    chk("mul_done", 32'(bus.select_done), 0);
    tick();
    chk("mul_err_held", 32'(bus.select_error), 1);
    chk("mul_a_held", 32'(bus.selected_a), 1);
    manual(3'd1, 4'd12, 4'd5);
    chk("range_code", 32'(bus.err_code), 4);
    chk("range_a", 32'(bus.selected_a), 12);
    start(1'b1, 3'd1);
    chk("restart_err", 32'(bus.select_error), 0);
    chk("restart_code", 32'(bus.err_code), 0);
    chk("restart_busy", 32'(bus.busy), 1);
    do_abort();
    chk("abort_wait_busy", 32'(bus.busy), 0);
    manual(3'd1, 4'd3, 4'd5);
    chk("a_invalid_code", 32'(bus.err_code), 1);
    manual(3'd1, 4'd2, 4'd6);
    chk("b_invalid_code", 32'(bus.err_code), 2);
    manual(3'd5, 4'd2, 4'd5);
    chk("bad_op_code", 32'(bus.err_code), 7);
    manual(3'd2, 4'd2, 4'd15);
    chk("scalar_ignores_b", 32'(bus.select_done), 1);
    tick();
    start(1'b1, 3'd1);
    repeat (19) tick();
    chk("tmo_not_yet", 32'(bus.select_error), 0);
    tick();
    chk("tmo_err", 32'(bus.select_error), 1);
    chk("tmo_code", 32'(bus.err_code), 5);
    clr_slots();
    set_slot(7, 1'b1, 3'd4, 3'd4);
    start(1'b0, 3'd4);
    wait_result("conv");
    chk("conv_done", 32'(bus.select_done), 1);
    chk("conv_a", 32'(bus.selected_a), 7);
    chk("conv_b", 32'(bus.selected_b), 7);
    chk("conv_code", 32'(bus.err_code), 0);
    tick();
    clr_slots();
    set_slot(0, 1'b1, 3'd2, 3'd3);
    set_slot(6, 1'b1, 3'd2, 3'd2);
    start(1'b0, 3'd3);
    l0 = lm;
    pa = pick(l0, 16'h0041, la, na);
    pb = pick(la, 16'h0041, lb, nb);
    wait_result("rmul");
    chk("rmul_done", 32'(bus.select_done), 32'(pa != 4'd0));
    chk("rmul_code", 32'(bus.err_code), pa == 4'd0 ? 6 : 0);
    chk("rmul_a", 32'(bus.selected_a), 32'(pa));
    chk("rmul_b", 32'(bus.selected_b), pa == 4'd0 ? 0 : 32'(pb));
    do_abort();
    chk("abort_clears_err", 32'(bus.select_error), 0);
    clr_slots();
    set_slot(0, 1'b1, 3'd2, 3'd3);
    start(1'b0, 3'd3);
    l0 = lm;
    pa = pick(l0, 16'h0001, la, na);
    repeat (na) tick();
    chk("randb_busy", 32'(bus.busy), 1);
    chk("randb_a", 32'(bus.selected_a), 0);
    do_abort();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_err", 32'(bus.select_error), 0);
    repeat (3) tick();
    chk("abort_no_done", 32'(bus.select_done), 0);
    chk("abort_no_err", 32'(bus.select_error), 0);
    set_slot(3, 1'b1, 3'd1, 3'd1);
    start(1'b0, 3'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_a", 32'(bus.selected_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
